// File: rtl/quad_pkg.sv
// Shared types and the Gray-step classifier used by every quadrature decoder channel.
package quad_pkg;

  typedef logic [1:0] phase_t;  // {a, b}

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RUN_CW,
    RUN_CCW,
    ABORT
  } detent_state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_CW,
    DIR_CCW,
    DIR_ILLEGAL
  } step_dir_t;

  // Successor of a phase when turning clockwise: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic phase_t cw_next(input phase_t p);
    case (p)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

  function automatic step_dir_t step_dir(input phase_t p, input phase_t n);
    if (n == p)               return DIR_NONE;
    else if (n == cw_next(p)) return DIR_CW;
    else if (p == cw_next(n)) return DIR_CCW;
    else                      return DIR_ILLEGAL;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// One quadrature channel: 2-flop synchroniser, stability filter, Gray-step decoder,
// optional detent (X1) state machine, wrapping position counter and sticky error flag.
module quad_channel
  import quad_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4,
  parameter int X4       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             cw_out,
  output logic             ccw_out,
  output logic [CNT_W-1:0] pos,
  output logic             err
);

  localparam int FCNT_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);

  phase_t            sync1_q, sync1_d;
  phase_t            sync2_q, sync2_d;
  phase_t            filt_q,  filt_d;
  phase_t            prev_q,  prev_d;
  logic [FCNT_W-1:0] fcnt_q,  fcnt_d;
  logic              init_q,  init_d;
  detent_state_t     state_q, state_d;
  logic [CNT_W-1:0]  pos_q,   pos_d;
  logic              err_q,   err_d;
  logic              cw_q,    cw_d;
  logic              ccw_q,   ccw_d;

  step_dir_t dir;
  assign dir = step_dir(prev_q, filt_q);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    sync1_d = {a, b};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    fcnt_d  = '0;
    prev_d  = prev_q;
    init_d  = init_q;
    state_d = state_q;
    pos_d   = pos_q;
    err_d   = err_q;
    cw_d    = 1'b0;
    ccw_d   = 1'b0;

    // Accept a new phase only after it has differed from the filtered one for FILT_LEN cycles.
    if (sync2_q != filt_q) begin
      if (fcnt_q == FCNT_LAST) filt_d = sync2_q;
      else                     fcnt_d = fcnt_q + 1'b1;
    end

    if (filt_q != prev_q) begin
      prev_d = filt_q;
      if (init_q) begin
        // The first accepted phase after reset is only a starting point; mid-cycle means no valid detent.
        init_d  = 1'b0;
        state_d = (filt_q == PH_00) ? IDLE : ABORT;
      end else if (dir == DIR_ILLEGAL) begin
        err_d   = 1'b1;
        state_d = (filt_q == PH_00) ? IDLE : ABORT;
      end else begin
        if (filt_q == PH_00) begin
          state_d = IDLE;
        end else begin
          case (state_q)
            IDLE:    state_d = (dir == DIR_CW) ? RUN_CW : RUN_CCW;
            RUN_CW:  state_d = (dir == DIR_CW) ? RUN_CW : ABORT;
            RUN_CCW: state_d = (dir == DIR_CCW) ? RUN_CCW : ABORT;
            default: state_d = ABORT;
          endcase
        end

        if (X4 != 0) begin
          cw_d  = (dir == DIR_CW);
          ccw_d = (dir == DIR_CCW);
        end else if (filt_q == PH_00) begin
          cw_d  = (state_q == RUN_CW)  && (dir == DIR_CW);
          ccw_d = (state_q == RUN_CCW) && (dir == DIR_CCW);
        end
      end
    end

    if (cw_d)       pos_d = pos_q + CNT_W'(1);
    else if (ccw_d) pos_d = pos_q - CNT_W'(1);

    // Clear overrides the count and the error but leaves the step pulse visible.
    if (clr) begin
      pos_d = '0;
      err_d = 1'b0;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= PH_00;
      sync2_q <= PH_00;
      filt_q  <= PH_00;
      prev_q  <= PH_00;
      fcnt_q  <= '0;
      init_q  <= 1'b1;
      state_q <= IDLE;
      pos_q   <= '0;
      err_q   <= 1'b0;
      cw_q    <= 1'b0;
      ccw_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      prev_q  <= prev_d;
      fcnt_q  <= fcnt_d;
      init_q  <= init_d;
      state_q <= state_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
      cw_q    <= cw_d;
      ccw_q   <= ccw_d;
    end
  end

  assign cw_out  = cw_q;
  assign ccw_out = ccw_q;
  assign pos     = pos_q;
  assign err     = err_q;

endmodule

// File: rtl/quad_decoder_multi.sv
// Multi-channel quadrature decoder: NCH independent channels, positions packed
// channel i at pos[i*CNT_W +: CNT_W].
module quad_decoder_multi
  import quad_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4,
  parameter int X4       = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       a,
  input  logic [NCH-1:0]       b,
  input  logic [NCH-1:0]       clr,
  output logic [NCH-1:0]       cw_out,
  output logic [NCH-1:0]       ccw_out,
  output logic [NCH*CNT_W-1:0] pos,
  output logic [NCH-1:0]       err
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    quad_channel #(
      .CNT_W    (CNT_W),
      .FILT_LEN (FILT_LEN),
      .X4       (X4)
    ) u_channel (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a[i]),
      .b       (b[i]),
      .clr     (clr[i]),
      .cw_out  (cw_out[i]),
      .ccw_out (ccw_out[i]),
      .pos     (pos[i*CNT_W +: CNT_W]),
      .err     (err[i])
    );
  end

endmodule

// File: tb/tb_quad_decoder_multi.sv
// Bench for quad_decoder_multi: three configurations driven by shared pins, checked every
// cycle against a phase-index reference model, plus directed detent/wrap/clear/reset checks.
module tb_quad_decoder_multi;

  localparam int F = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ph [2];
  logic [1:0] a, b, clr;

  assign a = {ph[1][1], ph[0][1]};
  assign b = {ph[1][0], ph[0][0]};

  logic [1:0]  cw_x4, ccw_x4, err_x4, cw_x1, ccw_x1, err_x1, cw_w4, ccw_w4, err_w4;
  logic [31:0] pos_x4, pos_x1;
  logic [7:0]  pos_w4;

  quad_decoder_multi #(.NCH(2), .CNT_W(16), .FILT_LEN(F), .X4(1)) u_x4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .cw_out(cw_x4), .ccw_out(ccw_x4), .pos(pos_x4), .err(err_x4));
  quad_decoder_multi #(.NCH(2), .CNT_W(16), .FILT_LEN(F), .X4(0)) u_x1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .cw_out(cw_x1), .ccw_out(ccw_x1), .pos(pos_x1), .err(err_x1));
  quad_decoder_multi #(.NCH(2), .CNT_W(4), .FILT_LEN(F), .X4(1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .cw_out(cw_w4), .ccw_out(ccw_w4), .pos(pos_w4), .err(err_w4));

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  string dname [3] = '{"x4", "x1", "w4"};
  int    x4_of [3] = '{1, 0, 1};
  int    w_of  [3] = '{16, 16, 4};

  // Reference model state, indexed [config][channel].
  int m_s1 [3][2], m_s2 [3][2], m_filt [3][2], m_fcnt [3][2], m_prev [3][2];
  int m_init [3][2], m_pos [3][2], m_err [3][2], m_cw [3][2], m_ccw [3][2];
  int h_ok [3][2], h_dir [3][2];
  int pc_cw [3][2], pc_ccw [3][2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_pos(input int m, input int ch);
    case (m)
      0:       return {16'h0, pos_x4[ch*16 +: 16]};
      1:       return {16'h0, pos_x1[ch*16 +: 16]};
      default: return {28'h0, pos_w4[ch*4 +: 4]};
    endcase
  endfunction

  function automatic logic [3:0] dut_bits(input int m, input int ch);
    // {cw, ccw, err}
    case (m)
      0:       return {1'b0, cw_x4[ch], ccw_x4[ch], err_x4[ch]};
      1:       return {1'b0, cw_x1[ch], ccw_x1[ch], err_x1[ch]};
      default: return {1'b0, cw_w4[ch], ccw_w4[ch], err_w4[ch]};
    endcase
  endfunction

  // Position of a phase along the clockwise cycle 00,01,11,10.
  function automatic int pidx(input int p);
    case (p)
      0:       return 0;
      1:       return 1;
      3:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++)
      for (int ch = 0; ch < 2; ch++) begin
        m_s1[m][ch] = 0; m_s2[m][ch] = 0; m_filt[m][ch] = 0; m_fcnt[m][ch] = 0;
        m_prev[m][ch] = 0; m_init[m][ch] = 1; m_pos[m][ch] = 0; m_err[m][ch] = 0;
        m_cw[m][ch] = 0; m_ccw[m][ch] = 0; h_ok[m][ch] = 1; h_dir[m][ch] = 0;
      end
  endtask

  task automatic emit(input int m, input int ch, input int dir);
    int md;
    md = 1 << w_of[m];
    if (dir > 0) m_cw[m][ch] = 1;
    else         m_ccw[m][ch] = 1;
    m_pos[m][ch] = (m_pos[m][ch] + dir + md) % md;
  endtask

  // Advance the model by one clock edge using the inputs currently on the pins.
  task automatic model_edge();
    int os1, os2, ofilt, ofcnt, oprev, d, dir;
    for (int m = 0; m < 3; m++)
      for (int ch = 0; ch < 2; ch++) begin
        os1 = m_s1[m][ch]; os2 = m_s2[m][ch]; ofilt = m_filt[m][ch];
        ofcnt = m_fcnt[m][ch]; oprev = m_prev[m][ch];
        m_s1[m][ch] = int'(ph[ch]);
        m_s2[m][ch] = os1;
        if (os2 != ofilt) begin
          if (ofcnt + 1 >= F) begin m_filt[m][ch] = os2; m_fcnt[m][ch] = 0; end
          else m_fcnt[m][ch] = ofcnt + 1;
        end else m_fcnt[m][ch] = 0;
        m_cw[m][ch] = 0;
        m_ccw[m][ch] = 0;
        if (ofilt != oprev) begin
          m_prev[m][ch] = ofilt;
          if (m_init[m][ch] != 0) begin
            m_init[m][ch] = 0;
            h_ok[m][ch] = (ofilt == 0) ? 1 : 0;
            h_dir[m][ch] = 0;
          end else begin
            d = (pidx(ofilt) - pidx(oprev) + 4) % 4;
            if (d == 2) begin
              m_err[m][ch] = 1;
              h_ok[m][ch] = (ofilt == 0) ? 1 : 0;
              h_dir[m][ch] = 0;
            end else begin
              dir = (d == 1) ? 1 : -1;
              if (x4_of[m] != 0) emit(m, ch, dir);
              else if (ofilt == 0) begin
                // Back at rest: a full detent only if every step since leaving 00 went this way.
                if (h_ok[m][ch] != 0 && h_dir[m][ch] == dir) emit(m, ch, dir);
                h_ok[m][ch] = 1;
                h_dir[m][ch] = 0;
              end else if (h_ok[m][ch] != 0 && h_dir[m][ch] == 0) h_dir[m][ch] = dir;
              else if (dir != h_dir[m][ch]) h_ok[m][ch] = 0;
            end
          end
        end
        if (clr[ch]) begin m_pos[m][ch] = 0; m_err[m][ch] = 0; end
      end
  endtask

  task automatic check_all();
    logic [3:0] bits;
    for (int m = 0; m < 3; m++)
      for (int ch = 0; ch < 2; ch++) begin
        bits = dut_bits(m, ch);
        check($sformatf("%s.%0d cw", dname[m], ch),  {31'h0, bits[2]}, m_cw[m][ch]);
        check($sformatf("%s.%0d ccw", dname[m], ch), {31'h0, bits[1]}, m_ccw[m][ch]);
        check($sformatf("%s.%0d err", dname[m], ch), {31'h0, bits[0]}, m_err[m][ch]);
        check($sformatf("%s.%0d pos", dname[m], ch), dut_pos(m, ch), m_pos[m][ch]);
      end
  endtask

  task automatic clear_counts();
    for (int m = 0; m < 3; m++)
      for (int ch = 0; ch < 2; ch++) begin pc_cw[m][ch] = 0; pc_ccw[m][ch] = 0; end
  endtask

  task automatic cycle();
    logic [3:0] bits;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    for (int m = 0; m < 3; m++)
      for (int ch = 0; ch < 2; ch++) begin
        bits = dut_bits(m, ch);
        pc_cw[m][ch]  += int'(bits[2]);
        pc_ccw[m][ch] += int'(bits[1]);
      end
  endtask

  task automatic hold(input int n);
    repeat (n) cycle();
  endtask

  // Apply a phase and hold 8 cycles; the X4 pulse must appear exactly on edge F+3.
  task automatic hold_timed(input int ch, input logic [1:0] v, input int exp_dir);
    ph[ch] = v;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check("x4 cw timing",  {31'h0, cw_x4[ch]},  {31'h0, (exp_dir > 0) && (k == F + 3)});
      check("x4 ccw timing", {31'h0, ccw_x4[ch]}, {31'h0, (exp_dir < 0) && (k == F + 3)});
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("async rst pos", pos_x4 | pos_x1 | {24'h0, pos_w4}, 32'h0);
    check("async rst flags", {26'h0, cw_x4 | cw_x1 | cw_w4, ccw_x4 | ccw_x1 | ccw_w4,
                              err_x4 | err_x1 | err_w4}, 32'h0);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic pulse_clr(input logic [1:0] c);
    clr = c;
    cycle();
    clr = 2'b00;
  endtask

  initial begin
    int r;
    ph[0] = 2'b11;
    ph[1] = 2'b11;
    clr = 2'b00;
    model_reset();

    // 1: reset with both phases at 11, then idle; init load must not count or flag.
    do_reset();
    clear_counts();
    hold(16);
    check("t1 x4 pos0", pos_x4, 32'h0);
    check("t1 pulses", pc_cw[0][0] + pc_ccw[0][0] + pc_cw[1][0] + pc_ccw[1][0], 0);
    check("t1 err", {30'h0, err_x4}, 32'h0);

    // Walk ch0 to rest and clear it.
    hold_timed(0, 2'b10, 1);
    hold_timed(0, 2'b00, 1);
    pulse_clr(2'b01);

    // 2: one full clockwise cycle.
    clear_counts();
    hold_timed(0, 2'b01, 1);
    hold_timed(0, 2'b11, 1);
    hold_timed(0, 2'b10, 1);
    hold_timed(0, 2'b00, 1);
    check("t2 x4 cw count", pc_cw[0][0], 4);
    check("t2 x4 pos0", dut_pos(0, 0), 32'd4);
    check("t2 x1 cw count", pc_cw[1][0], 1);
    check("t2 x1 pos0", dut_pos(1, 0), 32'd1);

    // 3: two counter-clockwise detents, then a half detent that reverses.
    pulse_clr(2'b01);
    clear_counts();
    repeat (2) begin
      hold_timed(0, 2'b10, -1);
      hold_timed(0, 2'b11, -1);
      hold_timed(0, 2'b01, -1);
      hold_timed(0, 2'b00, -1);
    end
    check("t3 x1 ccw count", pc_ccw[1][0], 2);
    check("t3 x1 pos0", dut_pos(1, 0), 32'hFFFE);
    check("t3 x4 pos0", dut_pos(0, 0), 32'hFFF8);
    check("t3 w4 pos0", dut_pos(2, 0), 32'h8);
    clear_counts();
    hold_timed(0, 2'b01, 1);
    hold_timed(0, 2'b11, 1);
    hold_timed(0, 2'b01, -1);
    hold_timed(0, 2'b00, -1);
    check("t3 half x1 pulses", pc_cw[1][0] + pc_ccw[1][0], 0);
    check("t3 half x1 pos0", dut_pos(1, 0), 32'hFFFE);

    // 4: 3-cycle glitch is filtered; a double-bit step flags err; clr resets it.
    clear_counts();
    ph[0] = 2'b10;
    hold(3);
    ph[0] = 2'b00;
    hold(8);
    check("t4 glitch pulses", pc_cw[0][0] + pc_ccw[0][0], 0);
    check("t4 glitch pos0", dut_pos(0, 0), 32'hFFF8);
    hold_timed(0, 2'b11, 0);
    check("t4 err x4", {31'h0, err_x4[0]}, 32'h1);
    check("t4 err x1", {31'h0, err_x1[0]}, 32'h1);
    check("t4 illegal pos0", dut_pos(0, 0), 32'hFFF8);
    hold_timed(0, 2'b10, 1);
    hold_timed(0, 2'b00, 1);
    pulse_clr(2'b01);
    check("t4 clr err", {31'h0, err_x4[0]}, 32'h0);
    check("t4 clr pos", dut_pos(0, 0), 32'h0);

    // 5: 4-bit wrap in both directions with a simultaneous step on ch1.
    hold_timed(0, 2'b10, -1);
    check("t5 w4 underflow", dut_pos(2, 0), 32'hF);
    ph[0] = 2'b00;
    ph[1] = 2'b01;
    hold(8);
    check("t5 w4 overflow", dut_pos(2, 0), 32'h0);
    check("t5 w4 pos1", dut_pos(2, 1), 32'hF);
    check("t5 x4 pos1", dut_pos(0, 1), 32'hFFFF);

    // 6: clr on the decode edge wins over the count but not the pulse; then reset mid-detent.
    ph[0] = 2'b01;
    hold(F + 2);
    clr = 2'b01;
    cycle();
    clr = 2'b00;
    check("t6 cw with clr", {31'h0, cw_x4[0]}, 32'h1);
    check("t6 pos cleared", dut_pos(0, 0), 32'h0);
    hold(3);
    ph[0] = 2'b11;
    hold(F + 1);
    do_reset();

    // Random walks on both channels, including glitches, illegal steps and clears.
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        r = $urandom_range(0, 99);
        if (r < 8)       ph[ch] = cw_step(ph[ch]);
        else if (r < 16) ph[ch] = ccw_step(ph[ch]);
        else if (r < 18) ph[ch] = ph[ch] ^ 2'b11;
        else if (r < 20) ph[ch] = 2'($urandom_range(0, 3));
      end
      clr = ($urandom_range(0, 99) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (i == 1500) do_reset();
      else cycle();
    end
    clr = 2'b00;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic [1:0] cw_step(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] ccw_step(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endmodule
